// File: rtl/udm_pkg.sv
// Shared definitions for the underdesigned sequential multiplier.
//   - accuracy mode encodings (per-operation selection)
//   - FSM state encoding for the iterative controller
//   - digit_count(): number of 2-bit digits in a W-bit operand
package udm_pkg;

  localparam logic [1:0] MODE_EXACT   = 2'b00;
  localparam logic [1:0] MODE_APPROX  = 2'b01;
  localparam logic [1:0] MODE_PARTIAL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic int digit_count(input int w);
    return w / 2;
  endfunction

endpackage

// File: rtl/udm_row.sv
// One row of 2x2 multiplier cells: full W-bit operand times a single 2-bit digit.
// Ports:
//   operand_i  W-bit multiplicand
//   digit_i    2-bit multiplier digit
//   mask_i     per-cell approximate enable, bit i controls operand digit i
//   row_o      (W+2)-bit row sum, cell i weighted by 4^i
// An approximate cell only differs from exact for 3x3, returning 7 instead of 9.
module udm_row #(
  parameter int W = 8
) (
  input  logic [W-1:0]   operand_i,
  input  logic [1:0]     digit_i,
  input  logic [W/2-1:0] mask_i,
  output logic [W+1:0]   row_o
);

  localparam int N = W / 2;

  logic [4*N-1:0] cells;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cell
      logic [1:0] a_dig;
      logic [3:0] prod;
      assign a_dig = operand_i[2*gi +: 2];
      assign prod  = {2'b00, a_dig} * {2'b00, digit_i};
      assign cells[4*gi +: 4] =
        (mask_i[gi] && (a_dig == 2'b11) && (digit_i == 2'b11)) ? 4'd7 : prod;
    end
  endgenerate

  // Max row is 9 * (4^N - 1) / 3 < 3 * 2^W, so W+2 bits never overflow.
  always_comb begin
    row_o = '0;
    for (int i = 0; i < N; i++) begin
      row_o = row_o + ((W+2)'(cells[4*i +: 4]) << (2 * i));
    end
  end

endmodule

// File: rtl/udm_seq_mult.sv
// Iterative underdesigned multiplier: one 2-bit multiplier digit per cycle
// against the full multiplicand, reusing a single row of W/2 2x2 cells.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    operand handshake (in1, in2, mode sampled on accept)
//   in1, in2             W-bit unsigned multiplicand / multiplier
//   mode                 00 exact, 01 all cells approximate, 10 partial, 11 exact
//   out_valid/out_ready  result handshake; res held stable while waiting
//   res                  2W-bit product
//   busy                 high while digits are being processed
module udm_seq_mult
  import udm_pkg::*;
#(
  parameter int W       = 8,
  parameter int APX_THR = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in1,
  input  logic [W-1:0]   in2,
  input  logic [1:0]     mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] res,
  output logic           busy
);

  localparam int N     = digit_count(W);
  localparam int JW    = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = 2 * W;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [1:0]       mode_q, mode_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [JW-1:0]    j_q, j_d;

  logic [N-1:0]     mask;
  logic [W+1:0]     row;

  // Cell (i, j) approximate-enable for the digit currently being processed.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      always_comb begin
        case (mode_q)
          MODE_APPROX:  mask[gi] = 1'b1;
          MODE_PARTIAL: mask[gi] = ((gi + int'(j_q)) < APX_THR);
          default:      mask[gi] = 1'b0;
        endcase
      end
    end
  endgenerate

  // b_q shifts right each RUN cycle, so its low digit is always digit j.
  udm_row #(.W(W)) u_row (
    .operand_i (a_q),
    .digit_i   (b_q[1:0]),
    .mask_i    (mask),
    .row_o     (row)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    j_d     = j_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in1;
          b_d     = in2;
          mode_d  = mode;
          acc_d   = '0;
          j_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_q + (ACC_W'(row) << {j_q, 1'b0});
        b_d   = b_q >> 2;
        j_d   = j_q + 1'b1;
        if (j_q == JW'(N - 1)) begin
          j_d     = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= MODE_EXACT;
      acc_q   <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      j_q     <= j_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign out_valid = (state_q == ST_DONE);
  assign res       = acc_q;

endmodule

// File: tb/tb_udm_seq_mult.sv
module tb_udm_seq_mult;

  localparam int W       = 8;
  localparam int APX_THR = 2;
  localparam int N       = W / 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in1 = '0;
  logic [W-1:0]   in2 = '0;
  logic [1:0]     mode = 2'b00;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] res;
  logic           busy;

  int checks = 0;
  int errors = 0;

  udm_seq_mult #(.W(W), .APX_THR(APX_THR)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: exact product minus 2*4^(i+j) for every approximated 3x3 digit pair.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] m);
    longint p;
    p = longint'(a) * longint'(b);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int  ai, bj;
        bit  apx;
        ai  = (a >> (2 * i)) & 3;
        bj  = (b >> (2 * j)) & 3;
        apx = (m == 2'b01) || ((m == 2'b10) && (i + j < APX_THR));
        if (apx && ai == 3 && bj == 3) p = p - (longint'(2) << (2 * (i + j)));
      end
    end
    return p[2*W-1:0];
  endfunction

  // Presents an operation and returns once it has been accepted (at posedge+1).
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m,
                      output bit ok);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    in_valid = 1'b1;
    in1 = a;
    in2 = b;
    mode = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in1 = W'($urandom);
    in2 = W'($urandom);
    mode = 2'($urandom);
  endtask

  // Waits for out_valid, counting cycles since accept (accept cycle = 0).
  task automatic wait_out(output logic [2*W-1:0] r, output int cyc, output bit ok);
    cyc = 1;
    while (!out_valid && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    ok = out_valid;
    r = res;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] m, input int exp_lat);
    bit ok_s, ok_o;
    logic [2*W-1:0] r, e;
    int cyc;
    send(a, b, m, ok_s);
    wait_out(r, cyc, ok_o);
    e = ref_mul(a, b, m);
    checks++;
    if (!ok_s || !ok_o || r !== e) begin
      errors++;
      $display("FAIL %s: a=%0d b=%0d mode=%0d res=%0d expected=%0d ok=%0d/%0d",
               name, a, b, m, r, e, ok_s, ok_o);
    end else begin
      $display("op %s: a=%0d b=%0d mode=%0d res=%0d lat=%0d", name, a, b, m, r, cyc);
    end
    if (exp_lat > 0) begin
      checks++;
      if (cyc !== exp_lat) begin
        errors++;
        $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_lat);
      end
    end
    if (ok_o) ack();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || res !== '0) begin
      errors++;
      $display("FAIL reset: in_ready=%0b out_valid=%0b busy=%0b res=%0d required 1 0 0 0",
               in_ready, out_valid, busy, res);
    end else $display("reset: idle state ok");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%0b out_valid=%0b busy=%0b", in_ready, out_valid, busy);
    end else $display("reset release: idle state ok");
  endtask

  task automatic test_directed();
    checks++;
    if (ref_mul(8'd255, 8'd255, 2'b01) !== 16'd50575 || ref_mul(8'd255, 8'd255, 2'b10) !== 16'd65007) begin
      errors++;
      $display("FAIL model_sanity: approx=%0d partial=%0d", ref_mul(8'd255, 8'd255, 2'b01),
               ref_mul(8'd255, 8'd255, 2'b10));
    end
    run_op("exact_max",   8'd255, 8'd255, 2'b00, N + 1);
    run_op("approx_max",  8'd255, 8'd255, 2'b01, N + 1);
    run_op("partial_max", 8'd255, 8'd255, 2'b10, N + 1);
    run_op("approx_6x7",  8'd6,   8'd7,   2'b01, N + 1);
    run_op("mode11_max",  8'd255, 8'd255, 2'b11, N + 1);
    run_op("zero",        8'd0,   8'd255, 2'b01, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] a, b;
      for (int d = 0; d < N; d++) begin
        a[2*d +: 2] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'($urandom);
        b[2*d +: 2] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'($urandom);
      end
      run_op($sformatf("rand%0d", k), a, b, 2'($urandom), 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  task automatic test_back_to_back();
    bit ok_s, ok_o;
    logic [2*W-1:0] r, held;
    int cyc, t0, t1;
    send(8'd200, 8'd123, 2'b00, ok_s);
    wait_out(held, cyc, ok_o);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (res !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold%0d: res=%0d (want %0d) in_ready=%0b out_valid=%0b", k, res, held,
                 in_ready, out_valid);
      end else $display("hold cycle %0d: res=%0d stable", k, res);
    end
    checks++;
    if (held !== ref_mul(8'd200, 8'd123, 2'b00) || !ok_o) begin
      errors++;
      $display("FAIL b2b_first: res=%0d expected %0d", held, ref_mul(8'd200, 8'd123, 2'b00));
    end
    ack();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: in_ready=%0b expected 1", in_ready);
    end else $display("b2b: in_ready back one cycle after handshake");
    run_op("b2b_3x3_approx", 8'd3, 8'd3, 2'b01, N + 1);

    // Throughput: in_valid and out_ready held high, measure accept spacing.
    t0 = -1;
    t1 = -1;
    @(negedge clk);
    in1 = 8'd17;
    in2 = 8'd9;
    mode = 2'b00;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && t1 < 0; c++) begin
      @(posedge clk);
      if (in_valid && in_ready) begin
        if (t0 < 0) t0 = c;
        else t1 = c;
      end
    end
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (t0 < 0 || t1 < 0 || (t1 - t0) != N + 2) begin
      errors++;
      $display("FAIL throughput: spacing=%0d expected %0d", t1 - t0, N + 2);
    end else $display("throughput: accept spacing %0d cycles", t1 - t0);
    wait_out(r, cyc, ok_o);
    checks++;
    if (!ok_o || r !== 16'd153) begin
      errors++;
      $display("FAIL stream_res: res=%0d expected 153", r);
    end
    if (ok_o) ack();
  endtask

  task automatic test_mid_reset();
    bit ok_s;
    send(8'd255, 8'd255, 2'b00, ok_s);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || res !== '0) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%0b busy=%0b res=%0d required 0 0 0", out_valid, busy, res);
    end else $display("mid-run reset: aborted cleanly");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: in_ready=%0b out_valid=%0b", in_ready, out_valid);
    end
    run_op("after_reset_13x11", 8'd13, 8'd11, 2'b00, N + 1);
  endtask

  task automatic test_mode_toggle();
    bit ok_s, ok_o;
    logic [2*W-1:0] r;
    int cyc;
    send(8'd255, 8'd255, 2'b10, ok_s);
    mode = 2'b01;
    in1 = 8'd0;
    in2 = 8'd0;
    @(posedge clk);
    #1;
    mode = 2'b00;
    wait_out(r, cyc, ok_o);
    checks++;
    if (!ok_o || r !== 16'd65007) begin
      errors++;
      $display("FAIL mode_toggle: res=%0d expected 65007", r);
    end else $display("mode toggle: res=%0d unaffected", r);
    if (ok_o) ack();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_mid_reset();
    test_mode_toggle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
